// File: rtl/uart_cmd_parser.sv
// Frame decoder for a UART byte stream: A5 | CMD | LEN | payload[LEN] | CSUM (XOR of CMD..payload).
// Good frames are presented on the cmd_* outputs; bad or stalled frames raise frame_err.
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned UART_BPS      = 115200,
    parameter int unsigned MAX_LEN       = 8,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_payload,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int unsigned TimeoutLimit = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
    localparam int unsigned CntW         = (TimeoutLimit > 1) ? $clog2(TimeoutLimit + 1) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutLimit - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutLimit);
    localparam logic [7:0] Header        = 8'hA5;
    localparam logic [7:0] MaxLenByte    = 8'(MAX_LEN);

    localparam logic [1:0] ErrLen     = 2'b01;
    localparam logic [1:0] ErrCsum    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StLen,
        StData,
        StCsum
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      xor_q, xor_d;
    logic [63:0]     buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      cmd_code_q, cmd_code_d;
    logic [3:0]      cmd_len_q, cmd_len_d;
    logic [63:0]     cmd_payload_q, cmd_payload_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            timeout_hit;

    // A byte arriving in the cycle the limit is reached wins over the timeout.
    assign timeout_hit = (state_q != StIdle) && !rx_done && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == StIdle) || rx_done) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        len_d         = len_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        buf_d         = buf_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;

        if (rx_done) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == Header) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    code_d  = rx_data;
                    xor_d   = rx_data;
                    idx_d   = '0;
                    // Clearing here keeps unused payload bytes zero for short frames.
                    buf_d   = '0;
                    state_d = StLen;
                end
                StLen: begin
                    xor_d = xor_q ^ rx_data;
                    len_d = rx_data[3:0];
                    if (rx_data > MaxLenByte) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ErrLen;
                        state_d     = StIdle;
                    end else if (rx_data == 8'h00) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    buf_d[{idx_q[2:0], 3'b000} +: 8] = rx_data;
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_d == len_q) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (rx_data == xor_q) begin
                        cmd_valid_d   = 1'b1;
                        cmd_code_d    = code_q;
                        cmd_len_d     = len_q;
                        cmd_payload_d = buf_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ErrCsum;
                    end
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ErrTimeout;
            state_d     = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            code_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            xor_q         <= '0;
            buf_q         <= '0;
            cnt_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_payload = cmd_payload_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized scoreboard bench for uart_cmd_parser: a queue-based frame model predicts every
// cmd_valid / frame_err pulse (cycle, kind, outputs) and a monitor checks them as they appear.
module tb_uart_cmd_parser;

    localparam int unsigned CLK_FREQ      = 1000;
    localparam int unsigned UART_BPS      = 100;
    localparam int unsigned MAX_LEN       = 8;
    localparam int unsigned TIMEOUT_BYTES = 2;
    localparam int unsigned LIMIT         = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (UART_BPS),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    typedef struct {
        bit          is_err;
        int unsigned cyc;
        logic [7:0]  code;
        logic [3:0]  len;
        logic [63:0] pl;
        logic [1:0]  ec;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    // Reference model state: bytes of the frame after the header, and the held outputs.
    bit          in_frame = 1'b0;
    logic [7:0]  fr[$];
    int unsigned last_edge = 0;
    logic [7:0]  h_code = '0;
    logic [3:0]  h_len  = '0;
    logic [63:0] h_pl   = '0;
    logic [1:0]  h_ec   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ok(input int unsigned s, input logic [7:0] c, input logic [3:0] l,
                           input logic [63:0] p);
        exp_t e;
        h_code = c;
        h_len  = l;
        h_pl   = p;
        e = '{is_err: 1'b0, cyc: s, code: h_code, len: h_len, pl: h_pl, ec: h_ec};
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int unsigned s, input logic [1:0] ec);
        exp_t e;
        h_ec = ec;
        e = '{is_err: 1'b1, cyc: s, code: h_code, len: h_len, pl: h_pl, ec: h_ec};
        exp_q.push_back(e);
    endtask

    // Byte b is sampled by the DUT at clock edge number s.
    task automatic model_byte(input logic [7:0] b, input int unsigned s);
        logic [7:0]  x;
        logic [63:0] p;
        int          n;
        last_edge = s;
        if (!in_frame) begin
            if (b == 8'hA5) begin
                in_frame = 1'b1;
                fr.delete();
            end
        end else begin
            fr.push_back(b);
            n = fr.size();
            if (n == 2 && int'(fr[1]) > int'(MAX_LEN)) begin
                push_err(s, 2'b01);
                in_frame = 1'b0;
            end else if (n >= 2 && n == int'(fr[1]) + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ fr[i];
                if (x == fr[n-1]) begin
                    p = '0;
                    for (int k = 0; k < int'(fr[1]); k++) p[8*k +: 8] = fr[2+k];
                    push_ok(s, fr[0], fr[1][3:0], p);
                end else begin
                    push_err(s, 2'b10);
                end
                in_frame = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; the byte is sampled at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        model_byte(b, cyc + 1);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int unsigned n);
        if (in_frame && last_edge + LIMIT <= cyc + n) begin
            push_err(last_edge + LIMIT, 2'b11);
            in_frame = 1'b0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic [7:0] len,
                              input logic [63:0] pl, input bit corrupt,
                              input int unsigned gapmax, input bit slow_csum);
        logic [7:0] x;
        send_byte(8'hA5);
        idle($urandom_range(0, gapmax));
        send_byte(code);
        idle($urandom_range(0, gapmax));
        send_byte(len);
        if (int'(len) <= int'(MAX_LEN)) begin
            x = code ^ len;
            for (int k = 0; k < int'(len); k++) begin
                idle($urandom_range(0, gapmax));
                send_byte(pl[8*k +: 8]);
                x = x ^ pl[8*k +: 8];
            end
            if (corrupt) x = x ^ 8'($urandom_range(1, 255));
            if (slow_csum) idle(LIMIT - 1);
            else idle($urandom_range(0, gapmax));
            send_byte(x);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(in_frame));
        check({tag, "_cmd_code"}, 64'(cmd_code), 64'(h_code));
        check({tag, "_cmd_len"}, 64'(cmd_len), 64'(h_len));
        check({tag, "_cmd_payload"}, cmd_payload, h_pl);
        check({tag, "_err_code"}, 64'(err_code), 64'(h_ec));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_cmd_code"}, 64'(cmd_code), 64'd0);
        check({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
        check({tag, "_cmd_payload"}, cmd_payload, 64'd0);
        check({tag, "_err_code"}, 64'(err_code), 64'd0);
        check({tag, "_no_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        in_frame = 1'b0;
        fr.delete();
        h_code = '0;
        h_len  = '0;
        h_pl   = '0;
        h_ec   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_pulse: got no strobe, expected %s at cycle %0d",
                         mon_e.is_err ? "frame_err" : "cmd_valid", mon_e.cyc);
            end
            if (cmd_valid || frame_err) begin
                check("exclusive_strobes", 64'(cmd_valid & frame_err), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: cmd_valid=%0b frame_err=%0b, expected none",
                             cmd_valid, frame_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("pulse_is_err", 64'(frame_err), 64'(mon_e.is_err));
                    check("cmd_code", 64'(cmd_code), 64'(mon_e.code));
                    check("cmd_len", 64'(cmd_len), 64'(mon_e.len));
                    check("cmd_payload", cmd_payload, mon_e.pl);
                    check("err_code", 64'(err_code), 64'(mon_e.ec));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned sel;
        logic [7:0]  b;
        @(negedge clk);
        do_reset("reset0");

        // Basic good frame, then the same frame with a bad checksum.
        send_frame(8'h10, 8'h02, 64'h2211, 1'b0, 0, 1'b0);
        idle(3);
        check_state("good2");
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
        idle(3);
        check_state("bad_csum");

        // Oversized length, then a zero-length frame.
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h09);
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
        idle(3);
        check_state("len_err_len0");

        // Noise before header; A5 inside payload and checksum is plain data.
        send_byte(8'h33); send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA5);
        idle(3);
        check_state("a5_as_data");

        // Full-length frame and one byte over the limit.
        send_frame(8'h7E, 8'(MAX_LEN), 64'hF0E1D2C3B4A59687, 1'b0, 1, 1'b0);
        send_frame(8'h7F, 8'(MAX_LEN + 1), 64'h0, 1'b0, 1, 1'b0);
        idle(3);
        check_state("max_len");

        // Timeout after silence, and a byte landing exactly on the limit cycle.
        send_byte(8'hA5); send_byte(8'h10);
        idle(LIMIT + 5);
        check_state("timeout");
        send_byte(8'hA5); send_byte(8'h10);
        idle(LIMIT - 1);
        send_byte(8'h00); send_byte(8'h10);
        idle(3);
        check_state("limit_edge");
        send_byte(8'hA5); send_byte(8'h10);
        idle(LIMIT);
        send_byte(8'h00);
        idle(3);
        check_state("limit_plus1");

        // Reset in the middle of the payload, then a clean frame.
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        check("mid_data_busy", 64'(busy), 64'd1);
        do_reset("reset_mid");
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h53);
        idle(3);
        check_state("after_reset");

        for (int it = 0; it < 120; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5: send_frame(8'($urandom), 8'($urandom_range(0, MAX_LEN)),
                              {$urandom, $urandom}, 1'b1, 2, 1'b0);
                6: send_frame(8'($urandom), 8'($urandom_range(MAX_LEN + 1, 255)),
                              64'h0, 1'b0, 2, 1'b0);
                7: begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h5A;
                    send_byte(b);
                end
                8: begin
                    send_byte(8'hA5);
                    for (int k = 0; k < int'($urandom_range(0, 4)); k++) send_byte(8'($urandom));
                    idle(LIMIT + $urandom_range(0, 3));
                end
                9: send_frame(8'($urandom), 8'($urandom_range(0, MAX_LEN)),
                              {$urandom, $urandom}, 1'b0, 1, 1'b1);
                default: send_frame(8'($urandom), 8'($urandom_range(0, MAX_LEN)),
                                    {$urandom, $urandom}, 1'b0, 2, 1'b0);
            endcase
            idle($urandom_range(0, 3));
        end
        idle(LIMIT + 5);
        check_state("final");
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
